// File: rtl/mult_ctrl_pkg.sv
// Shared constants and types for the multiplier-sharing controller.
package mult_ctrl_pkg;
  localparam int OPW = 8;
  localparam int PW  = 16;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MAC    = 2'b01,
    OP_CLRMAC = 2'b10,
    OP_RSV    = 2'b11
  } op_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
endpackage

// File: rtl/mult_share_ctrl_if.sv
// Request (A, B) and response handshake bundle for mult_share_ctrl.
interface mult_share_ctrl_if;
  import mult_ctrl_pkg::*;

  logic                  a_valid, a_ready;
  logic [1:0]            a_op;
  logic [OPW-1:0]        a_x, a_y;
  logic                  b_valid, b_ready;
  logic [1:0]            b_op;
  logic [OPW-1:0]        b_x, b_y;
  logic                  rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [PW-1:0]         rsp_data;
  logic                  busy;

  modport master (
    output a_valid, a_op, a_x, a_y, b_valid, b_op, b_x, b_y, rsp_ready,
    input  a_ready, b_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );

  modport slave (
    input  a_valid, a_op, a_x, a_y, b_valid, b_op, b_x, b_y, rsp_ready,
    output a_ready, b_ready, rsp_valid, rsp_id, rsp_data, rsp_ovf, busy
  );
endinterface

// File: rtl/mult8bit.sv
// Combinational 8x8 signed radix-4 Booth multiplier.
module mult8bit (
  input  logic signed [7:0]  x,
  input  logic signed [7:0]  y,
  output logic signed [15:0] p
);
  logic [8:0]         yb;
  logic signed [15:0] xe;
  logic signed [15:0] pp;

  assign yb = {y, 1'b0};
  assign xe = {{8{x[7]}}, x};

  always_comb begin
    p  = '0;
    pp = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      case (yb[2*i +: 3])
        3'b001, 3'b010: pp = xe;
        3'b011:         pp = xe <<< 1;
        3'b100:         pp = -(xe <<< 1);
        3'b101, 3'b110: pp = -xe;
        default:        pp = '0;
      endcase
      p = p + (pp <<< (2*i));
    end
  end
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; last winner loses the next tie.
module rr_arb2
  import mult_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic last;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == ID_B) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      last <= ID_B;
    else if (|gnt)
      last <= gnt[1] ? ID_B : ID_A;
  end
endmodule

// File: rtl/mult_share_ctrl.sv
// Two-requester controller sharing one Booth multiplier through a 2-stage pipe,
// with a per-requester 16-bit multiply-accumulate register.
module mult_share_ctrl
  import mult_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  mult_share_ctrl_if.slave bus
);
  logic                  s1_valid, s1_id;
  op_e                   s1_op;
  logic signed [OPW-1:0] s1_x, s1_y;
  logic                  s1_load, s2_load;
  logic [1:0]            gnt;
  logic signed [PW-1:0]  prod, acc_cur, sum;
  logic [PW-1:0]         acc [2];
  logic                  ovf_c;

  assign s2_load = s1_valid && (!bus.rsp_valid || bus.rsp_ready);
  assign s1_load = !s1_valid || s2_load;

  // Reset gates the enable so no ready is shown while rst is high.
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.b_valid, bus.a_valid}),
    .en  (s1_load && !rst),
    .gnt (gnt)
  );

  assign bus.a_ready = gnt[ID_A];
  assign bus.b_ready = gnt[ID_B];
  assign bus.busy    = s1_valid || bus.rsp_valid;

  mult8bit u_mult (
    .x (s1_x),
    .y (s1_y),
    .p (prod)
  );

  always_comb begin
    acc_cur = acc[s1_id];
    sum     = acc_cur + prod;
    ovf_c   = (acc_cur[PW-1] == prod[PW-1]) && (sum[PW-1] != acc_cur[PW-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= ID_A;
      s1_op    <= OP_MUL;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (|gnt) begin
      s1_valid <= 1'b1;
      s1_id    <= gnt[ID_B] ? ID_B : ID_A;
      s1_op    <= gnt[ID_B] ? op_e'(bus.b_op) : op_e'(bus.a_op);
      s1_x     <= gnt[ID_B] ? bus.b_x : bus.a_x;
      s1_y     <= gnt[ID_B] ? bus.b_y : bus.a_y;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= ID_A;
      bus.rsp_data  <= '0;
      bus.rsp_ovf   <= 1'b0;
      acc[0]        <= '0;
      acc[1]        <= '0;
    end else if (s2_load) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_id    <= s1_id;
      case (s1_op)
        OP_MAC: begin
          bus.rsp_data <= sum;
          bus.rsp_ovf  <= ovf_c;
          acc[s1_id]   <= sum;
        end
        OP_CLRMAC: begin
          bus.rsp_data <= prod;
          bus.rsp_ovf  <= 1'b0;
          acc[s1_id]   <= prod;
        end
        default: begin
          bus.rsp_data <= prod;
          bus.rsp_ovf  <= 1'b0;
        end
      endcase
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: vector table plus arbitration,
// backpressure and mid-flight reset sequences.
module tb_mult_share_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_acc  = 0;
  int   n_rsp  = 0;
  logic prev_gnt;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [7:0]  x, y;
    logic [15:0] data;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } exp_t;

  vec_t vt [14];
  exp_t q[$];
  logic [7:0] ax, ay, bx, by;

  mult_share_ctrl_if bus ();

  mult_share_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] xs, ys;
    xs = $signed(x);
    ys = $signed(y);
    return xs * ys;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    prev_gnt = 1'b1;
  endtask

  // Single transaction from one requester; checks latency and result.
  task automatic txn(input vec_t v, input string tag);
    logic got, seen;
    int   lat;
    logic [15:0] d;
    logic rid, rovf;
    got = 1'b0;
    bus.rsp_ready = 1'b1;
    if (v.id) begin
      bus.b_valid = 1'b1; bus.b_op = v.op; bus.b_x = v.x; bus.b_y = v.y;
    end else begin
      bus.a_valid = 1'b1; bus.a_op = v.op; bus.a_x = v.x; bus.a_y = v.y;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = v.id ? bus.b_ready : bus.a_ready;
      @(posedge clk);
      #1;
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    if (!got) begin
      chk({tag, "_accept"}, 32'd0, 32'd1);
      return;
    end
    seen = 1'b0; lat = 0; d = '0; rid = 1'b0; rovf = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1; lat = i; d = bus.rsp_data; rid = bus.rsp_id; rovf = bus.rsp_ovf;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_lat"},  lat,  32'd2);
    chk({tag, "_data"}, d,    v.data);
    chk({tag, "_id"},   rid,  v.id);
    chk({tag, "_ovf"},  rovf, v.ovf);
  endtask

  // Streams MUL commands; chk_alt verifies strict alternation under a tie.
  task automatic stream(input int ncyc, input logic va, input logic vb,
                        input logic rr, input logic chk_alt);
    logic ga, gb;
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      bus.a_valid = va; bus.a_op = 2'b00; bus.a_x = ax; bus.a_y = ay;
      bus.b_valid = vb; bus.b_op = 2'b00; bus.b_x = bx; bus.b_y = by;
      bus.rsp_ready = rr;
      @(negedge clk);
      ga = bus.a_ready;
      gb = bus.b_ready;
      if (ga && gb) chk("both_ready", 32'd1, 32'd0);
      if (chk_alt && va && vb) begin
        chk($sformatf("alt_accept_c%0d", c), ga | gb, 32'd1);
        chk($sformatf("alt_grant_c%0d", c), gb, !prev_gnt);
      end
      if (ga) begin
        q.push_back('{id: 1'b0, data: model_mul(ax, ay)});
        prev_gnt = 1'b0; n_acc++;
      end
      if (gb) begin
        q.push_back('{id: 1'b1, data: model_mul(bx, by)});
        prev_gnt = 1'b1; n_acc++;
      end
      if (bus.rsp_valid && rr) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("stream_data", bus.rsp_data, e.data);
          chk("stream_id",   bus.rsp_id,   e.id);
          n_rsp++;
        end
      end
      @(posedge clk);
      #1;
      if (ga) begin ax = ax + 8'd1; ay = ay + 8'd3; end
      if (gb) begin bx = bx - 8'd1; by = by + 8'd5; end
    end
  endtask

  initial begin
    int a0, r0;
    vt[0]  = '{1'b0, 2'b00, 8'hFD, 8'h07, 16'hFFEB, 1'b0};
    vt[1]  = '{1'b0, 2'b00, 8'h80, 8'h80, 16'h4000, 1'b0};
    vt[2]  = '{1'b0, 2'b10, 8'h0A, 8'h0A, 16'h0064, 1'b0};
    vt[3]  = '{1'b1, 2'b10, 8'h02, 8'h03, 16'h0006, 1'b0};
    vt[4]  = '{1'b0, 2'b01, 8'h05, 8'h04, 16'h0078, 1'b0};
    vt[5]  = '{1'b1, 2'b01, 8'h02, 8'h02, 16'h000A, 1'b0};
    vt[6]  = '{1'b0, 2'b10, 8'h7F, 8'h7F, 16'h3F01, 1'b0};
    vt[7]  = '{1'b0, 2'b01, 8'h7F, 8'h7F, 16'h7E02, 1'b0};
    vt[8]  = '{1'b0, 2'b01, 8'h7F, 8'h7F, 16'hBD03, 1'b1};
    vt[9]  = '{1'b1, 2'b01, 8'hFF, 8'h01, 16'h0009, 1'b0};
    vt[10] = '{1'b0, 2'b00, 8'h7F, 8'h80, 16'hC080, 1'b0};
    vt[11] = '{1'b0, 2'b11, 8'h03, 8'h03, 16'h0009, 1'b0};
    vt[12] = '{1'b0, 2'b01, 8'h00, 8'h00, 16'hBD03, 1'b0};
    vt[13] = '{1'b0, 2'b01, 8'h80, 8'h7F, 16'h7D83, 1'b1};

    ax = 8'h01; ay = 8'h03; bx = 8'hFF; by = 8'h05;
    bus.a_op = 2'b00; bus.a_x = '0; bus.a_y = '0;
    bus.b_op = 2'b00; bus.b_x = '0; bus.b_y = '0;
    bus.rsp_ready = 1'b1;
    prev_gnt = 1'b1;

    // Reset state, with both requesters asserting valid during reset.
    rst = 1'b1;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready",   bus.a_ready,   32'd0);
    chk("rst_b_ready",   bus.b_ready,   32'd0);
    chk("rst_rsp_valid", bus.rsp_valid, 32'd0);
    chk("rst_rsp_id",    bus.rsp_id,    32'd0);
    chk("rst_rsp_data",  bus.rsp_data,  32'd0);
    chk("rst_rsp_ovf",   bus.rsp_ovf,   32'd0);
    chk("rst_busy",      bus.busy,      32'd0);
    do_reset();

    for (int i = 0; i < 14; i++)
      txn(vt[i], $sformatf("v%0d", i));

    // Round-robin under continuous contention, full rate.
    do_reset();
    a0 = n_acc; r0 = n_rsp;
    stream(10, 1'b1, 1'b1, 1'b1, 1'b1);
    stream(3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("alt_accepts",   n_acc - a0, 32'd10);
    chk("alt_responses", n_rsp - r0, 32'd10);
    chk("alt_q_empty",   q.size(),   32'd0);

    // Backpressure: response stalled for 4 cycles.
    a0 = n_acc; r0 = n_rsp;
    stream(4, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_accepts", n_acc - a0, 32'd2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("bp_a_ready_%0d", k), bus.a_ready,   32'd0);
      chk($sformatf("bp_b_ready_%0d", k), bus.b_ready,   32'd0);
      chk($sformatf("bp_valid_%0d", k),   bus.rsp_valid, 32'd1);
      chk($sformatf("bp_data_%0d", k),    bus.rsp_data,  q[0].data);
      chk($sformatf("bp_id_%0d", k),      bus.rsp_id,    q[0].id);
      @(posedge clk);
      #1;
    end
    stream(4, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp_responses", n_rsp - r0, 32'd2);
    chk("bp_q_empty",   q.size(),   32'd0);
    @(negedge clk);
    chk("bp_idle_busy", bus.busy, 32'd0);
    @(posedge clk);
    #1;

    // Reset while both stages hold commands.
    stream(2, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_busy_before", bus.busy, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    prev_gnt = 1'b1;
    @(negedge clk);
    chk("mid_busy_after",  bus.busy,      32'd0);
    chk("mid_rsp_valid",   bus.rsp_valid, 32'd0);
    @(posedge clk);
    #1;
    stream(3, 1'b0, 1'b0, 1'b1, 1'b0);
    stream(1, 1'b1, 1'b1, 1'b1, 1'b1);
    stream(3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mid_q_empty", q.size(), 32'd0);
    txn('{1'b0, 2'b01, 8'h03, 8'h04, 16'h000C, 1'b0}, "mid_acc_a");
    txn('{1'b1, 2'b01, 8'h02, 8'hFF, 16'hFFFE, 1'b0}, "mid_acc_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Controller that shares one combinational 8x8 signed Booth multiplier (`mult8bit`) between two requesters, A and B. It performs round-robin arbitration, applies valid/ready handshakes on both request ports and on a single response port, and runs a 2-stage pipeline around the multiplier. It also keeps one 16-bit multiply-accumulate register per requester. It sits between the ALU front-end (requester A) and the coefficient/filter engine (requester B).

## Interface
- No parameters. Operand width is fixed at 8 bits and product width at 16 bits by the shared multiplier.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `a_valid` in 1: requester A command valid.
- `a_ready` out 1: A command accepted this cycle.
- `a_op` in 2: 00 MUL, 01 MAC, 10 CLRMAC, 11 reserved (treated as MUL).
- `a_x`, `a_y` in 8 each: signed two's-complement operands.
- `b_valid`, `b_ready`, `b_op`, `b_x`, `b_y`: same as A, for requester B.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response consumer ready.
- `rsp_id` out 1: requester of the response (0 = A, 1 = B).
- `rsp_data` out 16: result.
- `rsp_ovf` out 1: signed overflow on the accumulate add (MAC only).
- `busy` out 1: asserted when either pipeline stage is valid.

## Operation
- **Stage S1 (issue register):** holds `x`, `y`, `op`, `id`. The multiplier reads the S1 operands combinationally.
- **Stage S2 (response register):** drives the `rsp_*` outputs.
- **Advance rules:**
  - `s2_load = s1_valid && (!rsp_valid || rsp_ready)`.
  - `s1_load = !s1_valid || s2_load`.
- **Grant:** requester k is granted only when `s1_load` is 1.
  - Only one requester valid: grant it.
  - Both valid: grant the one not granted last.
  - `last` updates only on an actual grant. Reset value is `last=B`, so A wins the first tie.
- **Ready signals:** `a_ready = a_valid && s1_load && grant==A`; `b_ready` likewise. Ready may depend on valid. Valid must not depend on ready.
- **Handshake rule:** a requester holds `valid`, `op`, `x` and `y` stable until it sees `ready`.
- **Result, computed when S1 moves into S2** (p = signed product):
  - MUL: `rsp_data = p`; accumulator unchanged.
  - MAC: `rsp_data = acc[id] + p`, wrapping mod 2^16; `acc[id]` takes the same value.
  - CLRMAC: `rsp_data = p`; `acc[id] = p`.
- **Overflow:** `rsp_ovf` = 1 on MAC when the two addends have the same sign and the sum sign differs. It is 0 for all other ops.
- **Back-to-back MACs from one requester:** in-order commit makes a later MAC read the accumulator value written by the earlier one. No stall is required.
- **Accumulator isolation:** `acc[A]` and `acc[B]` are independent.
- **Reset:**
  - Clears `s1_valid`, `s2_valid`, both accumulators and `rsp_*`; sets `last=B`.
  - Transactions in flight are dropped silently; no response is produced for them.

## Timing
- **Reset values:** `a_ready=0`, `b_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `rsp_ovf=0`, `busy=0`.
- **Latency:** a command accepted at edge N has `rsp_valid=1` from the cycle after edge N+1. That is 2 cycles at full rate.
- **Throughput:** 1 command per cycle with `rsp_ready` held at 1.
- **Stalled response:** while `rsp_valid && !rsp_ready`, the `rsp_*` outputs hold stable. At most one more command is accepted, into S1, and then both readies go low.
- **Same-cycle events:** a drain and a new accept in the same cycle are legal, with S2 loading and S1 loading together.
- **Reset priority:** `rst` overrides every handshake in the same cycle.

## Structure
- **Package `mult_ctrl_pkg`:**
  - Op codes `OP_MUL`, `OP_MAC`, `OP_CLRMAC`.
  - IDs `ID_A=1'b0`, `ID_B=1'b1`.
  - Width constants `OPW=8`, `PW=16`.
- **Sub-modules:**
  - Instantiate the existing `mult8bit` unchanged as the datapath.
  - Factor the round-robin logic into `rr_arb2` (inputs `req[1:0]`, `en`; outputs `gnt[1:0]`; internal `last` register).

## Test plan
- **Single MUL, x=-3 (8'hFD), y=7:** A MUL → `rsp_data=16'hFFEB`, `rsp_id=0`, `rsp_ovf=0`, 2 cycles after accept. Same for x=y=8'h80 → `16'h4000`.
- **Alternating grants:** A and B both valid every cycle, `rsp_ready=1` → grants A,B,A,B…, starting with A, and one response per cycle in issue order.
- **Independent accumulators:**
  - A: CLRMAC 10×10, then MAC 5×4 → 16'h0064, then 16'h0078.
  - Interleaved B: CLRMAC 2×3 → 16'h0006.
  - `acc[A]` is unaffected by B.
- **Overflow:** A CLRMAC 127×127 (16'h3F01), MAC 127×127 (16'h7E02, `ovf=0`), MAC 127×127 → 16'hBD03 with `ovf=1`.
- **Backpressure:** `rsp_ready=0` for 4 cycles with both requesters valid → exactly 2 commands accepted, `rsp_*` stable, both readies low. After release, the responses drain in order with no loss or duplication.
- **Reset mid-flight:** `rst` pulsed for 1 cycle while S1 and S2 are both valid → no response for those commands, `busy=0` next cycle, accumulators at 0, first grant after reset goes to A.
